// File: rtl/hack_mem_responder_pkg.sv
// Shared definitions for the Hack CPU memory responder: sequencer states,
// address region bit and the instruction bits that decide operand traffic.
package hack_mem_responder_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    LOAD_I = 3'd1,
    PER_RD = 3'd2,
    PER_WR = 3'd3,
    RUN    = 3'd4
  } state_t;

  localparam int RAM_REGION_BIT = 14;
  localparam int C_BIT          = 15;
  localparam int A_BIT          = 12;
  localparam int DEST_M_BIT     = 3;

  // A C-instruction whose comp field uses M needs the operand read first.
  function automatic logic rd_need(input logic [15:0] instr);
    return instr[C_BIT] & instr[A_BIT];
  endfunction

  // A C-instruction with M among its destinations writes the operand back.
  function automatic logic wr_need(input logic [15:0] instr);
    return instr[C_BIT] & instr[DEST_M_BIT];
  endfunction

endpackage

// File: rtl/hack_mem_responder_per_handshake.sv
// Peripheral req/ack engine. The request follows 'active' except for one
// forced idle cycle after every completion, so back-to-back transactions are
// always separated. Optional ack watchdog: HACK_MEM_RESPONDER_TIMEOUT_EN.
module hack_mem_responder_per_handshake #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        active,
  input  logic        per_ack,
  input  logic [15:0] per_rdata,
  output logic        req,
  output logic        done,
  output logic [15:0] rdata,
  output logic        timed_out
);

`ifdef HACK_MEM_RESPONDER_TIMEOUT_EN
  localparam bit WATCHDOG_ON = 1'b1;
`else
  localparam bit WATCHDOG_ON = 1'b0;
`endif

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic             gap_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign req         = active & ~gap_q;
  assign timeout_hit = WATCHDOG_ON & req & ~per_ack &
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done        = req & (per_ack | timeout_hit);
  assign rdata       = timeout_hit ? 16'h0000 : per_rdata;
  assign timed_out   = timeout_hit;

  // Force request low for the cycle after each completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) gap_q <= 1'b0;
    else          gap_q <= done;
  end

  // Count cycles spent waiting for ack in the current request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            wait_cnt <= '0;
    else if (req && !done)   wait_cnt <= wait_cnt + CNT_W'(1);
    else                     wait_cnt <= '0;
  end

endmodule

// File: rtl/hack_mem_responder.sv
// Memory-side responder for the Hack CPU: fetches from ROM, waits for
// synchronous RAM data or slow peripheral transactions, and releases the CPU
// for exactly one run cycle per instruction. The peripheral ack watchdog and
// sticky error flag are enabled by HACK_MEM_RESPONDER_TIMEOUT_EN.
module hack_mem_responder
  import hack_mem_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] pc,
  input  logic [14:0] address_m,
  input  logic [15:0] out_m,
  input  logic        write_m,
  output logic [15:0] instruction,
  output logic [15:0] in_m,
  output logic        hold,
  output logic [14:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [13:0] ram_addr,
  input  logic [15:0] ram_rdata,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        per_req,
  output logic        per_we,
  output logic [14:0] per_addr,
  output logic [15:0] per_wdata,
  input  logic [15:0] per_rdata,
  input  logic        per_ack,
  output logic        error
);

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] rdata_q;
  logic        error_q;
  logic        per_region;
  logic        per_active;
  logic        hs_done;
  logic        hs_timed_out;
  logic [15:0] hs_rdata;

  assign per_region = address_m[RAM_REGION_BIT];
  assign per_active = (state_q == PER_RD) || (state_q == PER_WR);

  hack_mem_responder_per_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) per_handshake (
    .clock     (clock),
    .reset_n   (reset_n),
    .active    (per_active),
    .per_ack   (per_ack),
    .per_rdata (per_rdata),
    .req       (per_req),
    .done      (hs_done),
    .rdata     (hs_rdata),
    .timed_out (hs_timed_out)
  );

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Next state and per-state control; the LOAD_I decision looks at the word
  // arriving from ROM because instr_q only takes it at the end of that cycle.
  always_comb begin
    state_d = state_q;
    hold    = 1'b1;
    per_we  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      FETCH:  state_d = LOAD_I;
      LOAD_I: begin
        if (per_region && rd_need(rom_data))      state_d = PER_RD;
        else if (per_region && wr_need(rom_data)) state_d = PER_WR;
        else                                      state_d = RUN;
      end
      PER_RD: begin
        if (hs_done) state_d = wr_need(instr_q) ? PER_WR : RUN;
      end
      PER_WR: begin
        per_we = 1'b1;
        if (hs_done) state_d = RUN;
      end
      RUN: begin
        hold    = 1'b0;
        ram_we  = write_m & ~per_region;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Capture the fetched instruction and the peripheral read operand.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      if (state_q == LOAD_I)           instr_q <= rom_data;
      if (state_q == PER_RD && hs_done) rdata_q <= hs_rdata;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) error_q <= 1'b0;
    else          error_q <= error_q | hs_timed_out;
  end

  assign instruction = instr_q;
  assign in_m        = per_region ? rdata_q : ram_rdata;
  assign rom_addr    = pc;
  assign ram_addr    = address_m[RAM_REGION_BIT-1:0];
  assign ram_wdata   = out_m;
  assign per_addr    = address_m;
  assign per_wdata   = out_m;
  assign error       = error_q;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Self-checking bench for hack_mem_responder: ROM/RAM/peripheral models,
// an instruction-level reference model and directed plus random steps.
module tb_hack_mem_responder;

  localparam int          T_CYC = 8;
  localparam int unsigned NEVER = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
  } tx_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [14:0] pc, address_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] instruction, in_m;
  logic        hold;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic [13:0] ram_addr;
  logic [15:0] ram_rdata, ram_wdata;
  logic        ram_we;
  logic        per_req, per_we;
  logic [14:0] per_addr;
  logic [15:0] per_wdata, per_rdata;
  logic        per_ack;
  logic        error;

  logic [15:0] out_const;
  logic        alu_inc, wr_intent;
  logic [15:0] rom [0:255];
  logic [15:0] ram [0:16383];
  logic [15:0] ref_ram [0:16383];
  int unsigned ack_delay, req_age;
  logic [15:0] per_val;
  logic        stray_ack;

  int          req_starts, req_cycles, ram_we_cycles, unstable;
  tx_t         obs_q[$];
  logic [15:0] last_rd;
  logic        exp_err;
  int          n_checks = 0;
  int          n_errors = 0;
  int          waited, hold_low;

  // CPU side: ALU result is either a constant or M+1; writes gated by hold.
  assign out_m   = alu_inc ? in_m + 16'd1 : out_const;
  assign write_m = wr_intent & ~hold;

  hack_mem_responder #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .address_m(address_m),
    .out_m(out_m), .write_m(write_m), .instruction(instruction), .in_m(in_m),
    .hold(hold), .rom_addr(rom_addr), .rom_data(rom_data), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ack(per_ack),
    .error(error)
  );

  always #5 clock = ~clock;

  // Memories with one-cycle read latency and a peripheral that acks in
  // request cycle 'ack_delay' (0-based); stray acks appear only when idle.
  initial begin
    logic [14:0] rom_a_s;
    logic [13:0] ram_a_s;
    logic        ram_we_s;
    logic [15:0] ram_wd_s;
    rom_data = 16'h0; ram_rdata = 16'h0; per_ack = 1'b0; per_rdata = 16'h0;
    req_age = 0;
    forever begin
      @(negedge clock);
      rom_a_s = rom_addr; ram_a_s = ram_addr; ram_we_s = ram_we; ram_wd_s = ram_wdata;
      @(posedge clock);
      #1;
      rom_data  = rom[rom_a_s[7:0]];
      ram_rdata = ram[ram_a_s];
      if (ram_we_s) ram[ram_a_s] = ram_wd_s;
      if (per_req) begin
        per_ack   = (req_age == ack_delay);
        per_rdata = per_ack ? per_val : 16'hDEAD;
        req_age++;
      end else begin
        per_ack   = stray_ack;
        per_rdata = 16'hBEEF;
        req_age   = 0;
      end
    end
  end

  // Bus monitor: request starts, request cycles, stability and acked transfers.
  initial begin
    logic        prev_req, prev_we;
    logic [14:0] prev_addr;
    logic [15:0] prev_wdata;
    tx_t         t;
    prev_req = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clock);
      if (per_req) begin
        req_cycles++;
        if (!prev_req) req_starts++;
        else if (per_we !== prev_we || per_addr !== prev_addr ||
                 (per_we && per_wdata !== prev_wdata)) unstable++;
        if (per_ack) begin
          t.we = per_we; t.addr = per_addr; t.wdata = per_wdata;
          obs_q.push_back(t);
        end
      end
      if (ram_we) ram_we_cycles++;
      prev_req = per_req; prev_we = per_we; prev_addr = per_addr; prev_wdata = per_wdata;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_errors++;
        $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Run one instruction from FETCH (called just after a clock edge) and
  // compare against the instruction-level model.
  task automatic apply_stimulus(input logic [14:0] pc_v, input logic [15:0] instr,
                                input logic [14:0] a, input logic inc,
                                input logic [15:0] oc, input int unsigned d,
                                input logic [15:0] pv, input logic stray);
    logic        rd, wr, per, never;
    logic [15:0] exp_in, exp_out;
    int          tx_len, exp_req_cycles, exp_cycles, n_tx, cycles;
    tx_t         exp_q[$];
    tx_t         t;
    rd     = instr[15] & instr[12];
    wr     = instr[15] & instr[3];
    per    = a[14];
    never  = (d == NEVER);
    tx_len = never ? T_CYC : int'(d) + 1;
    if (per && rd)  exp_in = never ? 16'h0000 : pv;
    else if (per)   exp_in = last_rd;
    else            exp_in = ref_ram[a[13:0]];
    exp_out = inc ? exp_in + 16'd1 : oc;
    exp_req_cycles = 0;
    n_tx = 0;
    if (per && rd) begin
      exp_req_cycles += tx_len; n_tx++;
      t.we = 1'b0; t.addr = a; t.wdata = 16'h0;
      if (!never) exp_q.push_back(t);
    end
    if (per && wr) begin
      exp_req_cycles += tx_len; n_tx++;
      t.we = 1'b1; t.addr = a; t.wdata = exp_out;
      if (!never) exp_q.push_back(t);
    end
    exp_cycles = 3 + exp_req_cycles + ((per && rd && wr) ? 1 : 0);
    if (never && n_tx > 0) exp_err = 1'b1;

    pc = pc_v; rom[pc_v[7:0]] = instr; address_m = a; alu_inc = inc; out_const = oc;
    wr_intent = wr; ack_delay = d; per_val = pv; stray_ack = stray;
    req_starts = 0; req_cycles = 0; ram_we_cycles = 0; unstable = 0; obs_q.delete();

    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (hold && cycles < 200);
    check_output("cycles_to_run", cycles, exp_cycles);
    check_output("instruction", instruction, instr);
    check_output("in_m", in_m, exp_in);
    check_output("ram_we_in_run", ram_we, wr & ~per);
    check_output("ram_addr", ram_addr, a[13:0]);
    check_output("ram_wdata", ram_wdata, exp_out);
    check_output("per_req_in_run", per_req, 1'b0);
    check_output("error", error, exp_err);
    @(posedge clock);
    #2;
    check_output("hold_after_run", hold, 1'b1);
    check_output("ram_we_cycles", ram_we_cycles, wr & ~per);
    check_output("req_starts", req_starts, n_tx);
    check_output("req_cycles", req_cycles, exp_req_cycles);
    check_output("per_stable", unstable, 0);
    check_output("tx_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_output("tx_we", obs_q[i].we, exp_q[i].we);
      check_output("tx_addr", obs_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check_output("tx_wdata", obs_q[i].wdata, exp_q[i].wdata);
    end
    if (per && rd)  last_rd = never ? 16'h0000 : pv;
    if (wr && !per) ref_ram[a[13:0]] = exp_out;
  endtask

  // Directed and random steps.
  initial begin
    reset_n = 1'b0; pc = '0; address_m = 15'h4000; alu_inc = 1'b0; out_const = '0;
    wr_intent = 1'b0; ack_delay = 0; per_val = '0; stray_ack = 1'b0;
    last_rd = 16'h0; exp_err = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 16'($urandom); ref_ram[i] = ram[i];
    end
    ram[5] = 16'h1234; ref_ram[5] = 16'h1234;

    #1;
    check_output("rst_hold", hold, 1'b1);
    check_output("rst_per_req", per_req, 1'b0);
    check_output("rst_per_we", per_we, 1'b0);
    check_output("rst_error", error, 1'b0);
    check_output("rst_instruction", instruction, 16'h0);
    check_output("rst_in_m_rdata", in_m, 16'h0);
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b1;

    apply_stimulus(15'd0, 16'h0005, 15'd0,      1'b0, 16'h0000, 0, 16'h0000, 1'b0);
    apply_stimulus(15'd1, 16'hFC10, 15'd5,      1'b0, 16'h0000, 0, 16'h0000, 1'b0);
    apply_stimulus(15'd2, 16'hEFC8, 15'd7,      1'b0, 16'h0001, 0, 16'h0000, 1'b0);
    apply_stimulus(15'd3, 16'hEE88, 15'h4000,   1'b0, 16'hFFFF, 3, 16'h0000, 1'b0);
    apply_stimulus(15'd4, 16'hFDC8, 15'h6000,   1'b1, 16'h0000, 2, 16'h0041, 1'b1);
    apply_stimulus(15'd5, 16'hFC10, 15'h4001,   1'b0, 16'h1111, 0, 16'h00AA, 1'b0);
    apply_stimulus(15'd6, 16'h4003, 15'h4003,   1'b0, 16'h2222, 0, 16'h0000, 1'b1);
    apply_stimulus(15'd7, 16'hFC10, 15'd7,      1'b0, 16'h0000, 0, 16'h0000, 1'b1);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] ri;
      if ($urandom_range(0, 3) == 0) ri = {1'b0, 15'($urandom)};
      else                           ri = {3'b111, 13'($urandom)};
      apply_stimulus(15'($urandom), ri, 15'($urandom), 1'($urandom), 16'($urandom),
                     $urandom_range(0, 5), 16'($urandom), 1'($urandom));
    end

`ifdef HACK_MEM_RESPONDER_TIMEOUT_EN
    apply_stimulus(15'd10, 16'hFC10, 15'h4005, 1'b0, 16'h0000, 0, 16'h00AA, 1'b0);
    apply_stimulus(15'd11, 16'hFC10, 15'h4006, 1'b0, 16'h0000, NEVER, 16'h5555, 1'b0);
    apply_stimulus(15'd12, 16'hFC10, 15'd5,    1'b0, 16'h0000, 0, 16'h0000, 1'b0);
`endif

    pc = 15'd20; rom[20] = 16'hFC10; address_m = 15'h4002; wr_intent = 1'b0;
    alu_inc = 1'b0; ack_delay = NEVER; stray_ack = 1'b0;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!per_req && waited < 20);
    check_output("req_started", per_req, 1'b1);
`ifndef HACK_MEM_RESPONDER_TIMEOUT_EN
    hold_low = 0;
    repeat (300) begin
      @(negedge clock);
      if (!hold) hold_low++;
    end
    check_output("stuck_hold_low", hold_low, 0);
    check_output("stuck_req", per_req, 1'b1);
`else
    repeat (2) @(negedge clock);
`endif
    stray_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_per_req", per_req, 1'b0);
    check_output("mid_rst_hold", hold, 1'b1);
    check_output("mid_rst_per_we", per_we, 1'b0);
    check_output("mid_rst_error", error, 1'b0);
    @(posedge clock); #2;
    check_output("in_rst_hold", hold, 1'b1);
    reset_n = 1'b1; last_rd = 16'h0; exp_err = 1'b0;

    apply_stimulus(15'd21, 16'hFC10, 15'd5,    1'b0, 16'h0000, 0, 16'h0000, 1'b1);
    apply_stimulus(15'd22, 16'h0123, 15'h4010, 1'b0, 16'h3333, 0, 16'h0000, 1'b1);
    apply_stimulus(15'd23, 16'hFDC8, 15'h4011, 1'b1, 16'h0000, 0, 16'hFFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
